// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control unit for the accumulator core (REG/TGT/IMM/HALT decode modes).
// Optional illegal-encoding trap: define CTRL_SEQ_ILLEGAL_TRAP_EN.
module ctrl_seq #(
    parameter int IW  = 9,
    parameter int DW  = 8,
    parameter int MAW = 8,
    parameter int PCW = 9
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [IW-1:0]  Instruction,
    input  logic           InstrValid,
    input  logic [2:0]     CMPBits,
    input  logic           MemReady,
    output logic           BranchEn,
    output logic           SkipEn,
    output logic           PCHold,
    output logic [PCW-1:0] BranchTarget,
    output logic [MAW-1:0] MemoryTarget,
    output logic           MemAddrCtrl,
    output logic           MemValueCtrl,
    output logic           MemWrEn,
    output logic           MemRdEn,
    output logic [3:0]     OPCode,
    output logic [1:0]     ALUInput,
    output logic           ALUInputASelector,
    output logic [DW-1:0]  ImmediateOut,
    output logic           AccLoadEn,
    output logic           RegLoadEn,
    output logic           AccClr,
    output logic           RegClr,
    output logic           CMPLoadEn,
    output logic           LFSRSetState,
    output logic           LFSRSetTapPtrn,
    output logic           LFSRShift,
    output logic           Ack,
    output logic           Illegal,
    output logic [1:0]     State
);
    typedef enum logic [1:0] {
        ST_REG  = 2'b00,
        ST_TGT  = 2'b01,
        ST_IMM  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [3:0] OP_ADD      = 4'h1;
    localparam logic [3:0] OP_ADM      = 4'h3;
    localparam logic [3:0] OP_RSH      = 4'h4;
    localparam logic [3:0] OP_LSH      = 4'h9;
    localparam logic [3:0] OP_RSH_FILL = 4'hA;
    localparam logic [3:0] OP_LSH_FILL = 4'hB;

    state_t        state_q, state_d;
    logic [IW-1:0] prev_q;
    logic          illegal_q, illegal_set;

    logic       cls, pcls, taken, undef;
    logic [3:0] op, pop, fn, pfn;
    logic [1:0] arg;
    logic       exec_en, exec_fill;
    logic [3:0] exec_op;

    assign cls  = Instruction[IW-1];
    assign op   = Instruction[IW-2 -: 4];
    assign arg  = Instruction[3:2];
    assign fn   = Instruction[3:0];
    assign pcls = prev_q[IW-1];
    assign pop  = prev_q[IW-2 -: 4];
    assign pfn  = prev_q[3:0];

    assign BranchTarget = Instruction[PCW-1:0];
    assign MemoryTarget = Instruction[MAW-1:0];
    assign ImmediateOut = Instruction[DW-1:0];
    assign State        = state_q;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    function automatic logic is_math(input logic [3:0] o);
        return (o >= 4'h1) && (o <= 4'h9);
    endfunction

    // Fill-form shifts get their own ALU codes in the otherwise unused 1010/1011 slots.
    function automatic logic [3:0] alu_code(input logic [3:0] o, input logic fill);
        if (fill && o == OP_RSH) return OP_RSH_FILL;
        if (fill && o == OP_LSH) return OP_LSH_FILL;
        return o;
    endfunction

    function automatic logic branch_taken(input logic [3:0] o, input logic [2:0] c);
        logic eq, gt, lt;
        eq = c[1];
        gt = c[0] & ~c[1];
        lt = ~c[0] & ~c[1];
        case (o)
            4'h8:    return 1'b1;
            4'h9:    return c[2];
            4'hA:    return gt;
            4'hB:    return gt | eq;
            4'hC:    return lt;
            4'hD:    return lt | eq;
            4'hE:    return eq;
            4'hF:    return ~eq;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        taken = branch_taken(op, CMPBits);
        if (cls)
            undef = ~op[3];
        else if (op == 4'h0)
            undef = (fn == 4'h7) || ((fn >= 4'h9) && (fn <= 4'hB));
        else if (is_math(op))
            undef = ((op == OP_RSH) || (op == OP_LSH)) && (arg == 2'b11);
        else
            undef = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_REG;
            prev_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (InstrValid && !PCHold)
                prev_q <= Instruction;
            if (illegal_set)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_set = 1'b0;
        if (InstrValid) begin
            case (state_q)
                ST_REG: begin
                    if (undef) begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                        state_d     = ST_HALT;
                        illegal_set = 1'b1;
`else
                        state_d     = ST_REG;
`endif
                    end else if (cls) begin
                        if (taken) state_d = ST_TGT;
                    end else if (op == 4'h0) begin
                        if (fn == 4'hC || fn == 4'hD) state_d = ST_TGT;
                        else if (fn == 4'hF)          state_d = ST_HALT;
                    end else if (arg == 2'b10) begin
                        state_d = ST_IMM;
                    end else if (arg == 2'b01) begin
                        state_d = ST_TGT;
                    end
                end
                ST_TGT:  if (pcls || pop == 4'h0 || MemReady) state_d = ST_REG;
                ST_IMM:  state_d = ST_REG;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        BranchEn = 1'b0; SkipEn = 1'b0; PCHold = 1'b0;
        MemAddrCtrl = 1'b0; MemValueCtrl = 1'b0; MemWrEn = 1'b0; MemRdEn = 1'b0;
        OPCode = '0; ALUInput = '0; ALUInputASelector = 1'b0;
        AccLoadEn = 1'b0; RegLoadEn = 1'b0; AccClr = 1'b0; RegClr = 1'b0; CMPLoadEn = 1'b0;
        LFSRSetState = 1'b0; LFSRSetTapPtrn = 1'b0; LFSRShift = 1'b0; Ack = 1'b0;
        exec_en = 1'b0; exec_op = '0; exec_fill = 1'b0;
        if (!Reset) begin
            if (state_q == ST_HALT) begin
                Ack    = ~illegal_q;
                PCHold = 1'b1;
            end else if (!InstrValid) begin
                PCHold = 1'b1;
            end else begin
                case (state_q)
                    ST_REG: if (!undef) begin
                        if (cls) begin
                            SkipEn = ~taken;
                        end else if (op == 4'h0) begin
                            case (fn)
                                4'h1: AccClr         = 1'b1;
                                4'h2: RegClr         = 1'b1;
                                4'h3: LFSRSetState   = 1'b1;
                                4'h4: LFSRSetTapPtrn = 1'b1;
                                4'h5: LFSRShift      = 1'b1;
                                4'h6: begin
                                    MemRdEn = 1'b1;
                                    PCHold  = ~MemReady;
                                    if (MemReady) begin
                                        OPCode    = OP_ADD;
                                        ALUInput  = 2'b01;
                                        AccLoadEn = 1'b1;
                                    end
                                end
                                4'h8: CMPLoadEn = 1'b1;
                                4'hE: begin
                                    MemWrEn      = 1'b1;
                                    MemValueCtrl = 1'b1;
                                end
                                4'hF: Ack = 1'b1;
                                default: ;
                            endcase
                        end else if (arg == 2'b00 || arg == 2'b11) begin
                            ALUInput  = arg;
                            exec_en   = 1'b1;
                            exec_op   = op;
                            exec_fill = Instruction[1];
                        end
                    end
                    ST_TGT: begin
                        if (pcls) begin
                            BranchEn = 1'b1;
                        end else if (pop == 4'h0) begin
                            MemAddrCtrl  = 1'b1;
                            MemWrEn      = 1'b1;
                            MemValueCtrl = (pfn == 4'hC);
                        end else begin
                            MemAddrCtrl = 1'b1;
                            MemRdEn     = 1'b1;
                            ALUInput    = 2'b01;
                            PCHold      = ~MemReady;
                            exec_en     = MemReady;
                            exec_op     = pop;
                            exec_fill   = prev_q[1];
                        end
                    end
                    ST_IMM: begin
                        ALUInput  = 2'b10;
                        exec_en   = 1'b1;
                        exec_op   = pop;
                        exec_fill = prev_q[1];
                    end
                    default: ;
                endcase
                if (exec_en) begin
                    OPCode = alu_code(exec_op, exec_fill);
                    if (exec_op == OP_ADM) begin
                        ALUInputASelector = 1'b1;
                        RegLoadEn         = 1'b1;
                    end else begin
                        AccLoadEn = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed steps plus random instructions against a mode-level model.
module tb_ctrl_seq;
    localparam int IW = 9, DW = 8, MAW = 8, PCW = 9;

    logic           Clk = 1'b0;
    logic           Reset, InstrValid, MemReady;
    logic [IW-1:0]  Instruction;
    logic [2:0]     CMPBits;
    logic           BranchEn, SkipEn, PCHold, MemAddrCtrl, MemValueCtrl, MemWrEn, MemRdEn;
    logic [PCW-1:0] BranchTarget;
    logic [MAW-1:0] MemoryTarget;
    logic [3:0]     OPCode;
    logic [1:0]     ALUInput, State;
    logic           ALUInputASelector;
    logic [DW-1:0]  ImmediateOut;
    logic           AccLoadEn, RegLoadEn, AccClr, RegClr, CMPLoadEn;
    logic           LFSRSetState, LFSRSetTapPtrn, LFSRShift, Ack, Illegal;

    always #5 Clk = ~Clk;

    ctrl_seq #(.IW(IW), .DW(DW), .MAW(MAW), .PCW(PCW)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
        .CMPBits(CMPBits), .MemReady(MemReady), .BranchEn(BranchEn), .SkipEn(SkipEn),
        .PCHold(PCHold), .BranchTarget(BranchTarget), .MemoryTarget(MemoryTarget),
        .MemAddrCtrl(MemAddrCtrl), .MemValueCtrl(MemValueCtrl), .MemWrEn(MemWrEn),
        .MemRdEn(MemRdEn), .OPCode(OPCode), .ALUInput(ALUInput),
        .ALUInputASelector(ALUInputASelector), .ImmediateOut(ImmediateOut),
        .AccLoadEn(AccLoadEn), .RegLoadEn(RegLoadEn), .AccClr(AccClr), .RegClr(RegClr),
        .CMPLoadEn(CMPLoadEn), .LFSRSetState(LFSRSetState), .LFSRSetTapPtrn(LFSRSetTapPtrn),
        .LFSRShift(LFSRShift), .Ack(Ack), .Illegal(Illegal), .State(State)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: pending work after an instruction word, not the DUT's state register.
    localparam int P_NONE = 0, P_BRANCH = 1, P_STORE = 2, P_MEMOP = 3, P_IMM = 4;
    bit m_halt, m_ill, n_halt, n_ill, last_rst;
    int m_pend, n_pend, m_saved, n_saved;

    bit e_br, e_skip, e_hold, e_mac, e_mvc, e_wr, e_rd, e_asel, e_accld, e_regld;
    bit e_accclr, e_regclr, e_cmpld, e_lss, e_lst, e_lsh, e_ack;
    bit [3:0] e_opc;
    bit [1:0] e_alub;

    function automatic bit [1:0] mode_code();
        if (m_halt) return 2'd3;
        if (m_pend == P_IMM) return 2'd2;
        if (m_pend != P_NONE) return 2'd1;
        return 2'd0;
    endfunction

    function automatic void do_math(int ins);
        int  op   = (ins >> 4) & 15;
        bit  fill = ((ins >> 1) & 1) != 0;
        e_opc = 4'(op);
        if (fill && op == 4) e_opc = 4'd10;
        if (fill && op == 9) e_opc = 4'd11;
        if (op == 3) begin e_asel = 1; e_regld = 1; end
        else e_accld = 1;
    endfunction

    function automatic void model_eval(int ins, bit v, bit [2:0] cmp, bit mr, bit rst);
        int cls = ins >> 8;
        int op  = (ins >> 4) & 15;
        int arg = (ins >> 2) & 3;
        int fn  = ins & 15;
        bit eq  = cmp[1];
        bit gt  = cmp[0] && !eq;
        bit lt  = !cmp[0] && !eq;
        bit undef, taken;
        {e_br, e_skip, e_hold, e_mac, e_mvc, e_wr, e_rd, e_asel, e_accld, e_regld} = '0;
        {e_accclr, e_regclr, e_cmpld, e_lss, e_lst, e_lsh, e_ack} = '0;
        e_opc = 0; e_alub = 0;
        n_halt = m_halt; n_ill = m_ill; n_pend = m_pend; n_saved = m_saved;
        undef = (cls == 1 && op < 8) || (cls == 0 && op > 9) ||
                (cls == 0 && op == 0 && (fn == 7 || (fn >= 9 && fn <= 11))) ||
                (cls == 0 && (op == 4 || op == 9) && arg == 3);
        case (op)
            8: taken = 1; 9: taken = cmp[2]; 10: taken = gt; 11: taken = gt || eq;
            12: taken = lt; 13: taken = lt || eq; 14: taken = eq; 15: taken = !eq;
            default: taken = 0;
        endcase
        if (rst) begin
        end else if (m_halt) begin
            e_ack = !m_ill; e_hold = 1;
        end else if (!v) begin
            e_hold = 1;
        end else if (m_pend == P_BRANCH) begin
            e_br = 1; n_pend = P_NONE;
        end else if (m_pend == P_STORE) begin
            e_mac = 1; e_wr = 1; e_mvc = ((m_saved & 15) == 12); n_pend = P_NONE;
        end else if (m_pend == P_MEMOP) begin
            e_mac = 1; e_rd = 1; e_alub = 1;
            if (mr) begin do_math(m_saved); n_pend = P_NONE; end
            else e_hold = 1;
        end else if (m_pend == P_IMM) begin
            e_alub = 2; do_math(m_saved); n_pend = P_NONE;
        end else if (undef) begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            n_halt = 1; n_ill = 1;
`endif
        end else if (cls == 1) begin
            if (taken) begin n_pend = P_BRANCH; n_saved = ins; end
            else e_skip = 1;
        end else if (op == 0) begin
            case (fn)
                1: e_accclr = 1; 2: e_regclr = 1; 3: e_lss = 1; 4: e_lst = 1; 5: e_lsh = 1;
                6: begin
                    e_rd = 1;
                    if (mr) begin e_opc = 1; e_alub = 1; e_accld = 1; end
                    else e_hold = 1;
                end
                8: e_cmpld = 1;
                12, 13: begin n_pend = P_STORE; n_saved = ins; end
                14: begin e_wr = 1; e_mvc = 1; end
                15: begin e_ack = 1; n_halt = 1; end
                default: ;
            endcase
        end else if (arg == 2) begin
            n_pend = P_IMM; n_saved = ins;
        end else if (arg == 1) begin
            n_pend = P_MEMOP; n_saved = ins;
        end else begin
            e_alub = 2'(arg); do_math(ins);
        end
    endfunction

    task automatic apply(input int ins, input bit v, input bit [2:0] cmp, input bit mr,
                         input bit rst, input string tag);
        logic [25:0] exp_ctl, obs_ctl;
        logic [24:0] exp_dat;
        logic [8:0]  w;
        Instruction = 9'(ins); InstrValid = v; CMPBits = cmp; MemReady = mr; Reset = rst;
        last_rst = rst;
        #2;
        model_eval(ins, v, cmp, mr, rst);
        exp_ctl = {e_br, e_skip, e_hold, e_mac, e_mvc, e_wr, e_rd, e_opc, e_alub, e_asel,
                   e_accld, e_regld, e_accclr, e_regclr, e_cmpld, e_lss, e_lst, e_lsh,
                   e_ack, m_ill, mode_code()};
        obs_ctl = {BranchEn, SkipEn, PCHold, MemAddrCtrl, MemValueCtrl, MemWrEn, MemRdEn,
                   OPCode, ALUInput, ALUInputASelector, AccLoadEn, RegLoadEn, AccClr,
                   RegClr, CMPLoadEn, LFSRSetState, LFSRSetTapPtrn, LFSRShift, Ack,
                   Illegal, State};
        w = 9'(ins);
        exp_dat = {w, w[7:0], w[7:0]};
        chk({tag, "_ctl"}, 32'(obs_ctl), 32'(exp_ctl));
        chk({tag, "_data"}, 32'({BranchTarget, MemoryTarget, ImmediateOut}), 32'(exp_dat));
    endtask

    task automatic tick();
        @(posedge Clk);
        if (last_rst) begin
            m_halt = 0; m_ill = 0; m_pend = P_NONE; m_saved = 0;
        end else begin
            m_halt = n_halt; m_ill = n_ill; m_pend = n_pend; m_saved = n_saved;
        end
        #1;
    endtask

    initial begin
        int ins, r;
        bit v, mr, rs;
        bit [2:0] c;
        Reset = 1; Instruction = '0; InstrValid = 0; CMPBits = '0; MemReady = 0;
        m_halt = 0; m_ill = 0; m_pend = P_NONE; m_saved = 0; last_rst = 1;
        @(posedge Clk); @(posedge Clk); #1;
        apply(0, 1, 0, 0, 1, "rst"); tick();
        chk("reset_state", 32'(State), 0);
        chk("reset_ack_ill", 32'({Ack, Illegal}), 0);

        apply('h018, 1, 0, 0, 0, "addi_op"); chk("addi_c1_accld", 32'(AccLoadEn), 0); tick();
        chk("addi_state_imm", 32'(State), 2);
        apply('h005, 1, 0, 0, 0, "addi_imm");
        chk("addi_accld", 32'(AccLoadEn), 1);
        chk("addi_opcode", 32'(OPCode), 1);
        chk("addi_alub", 32'(ALUInput), 2);
        chk("addi_imm_out", 32'(ImmediateOut), 'h05);
        tick();

        apply('h1E0, 1, 3'b010, 0, 0, "beq_t"); tick();
        chk("beq_t_state", 32'(State), 1);
        apply('h023, 1, 0, 0, 0, "beq_tgt");
        chk("beq_branchen", 32'(BranchEn), 1);
        chk("beq_target", 32'(BranchTarget), 'h023);
        tick();

        apply('h1E0, 1, 3'b000, 0, 0, "beq_nt");
        chk("beq_nt_skip", 32'(SkipEn), 1);
        chk("beq_nt_branch", 32'(BranchEn), 0);
        tick(); chk("beq_nt_state", 32'(State), 0);

        apply('h00E, 0, 0, 1, 0, "novalid");
        chk("novalid_hold", 32'(PCHold), 1);
        chk("novalid_wr", 32'(MemWrEn), 0);
        tick();

        apply('h014, 1, 0, 0, 0, "tr_op"); tick();
        for (int k = 0; k < 2; k++) begin
            apply('h010, 1, 0, 0, 0, "tr_stall");
            chk("tr_stall_hold", 32'(PCHold), 1);
            chk("tr_stall_accld", 32'(AccLoadEn), 0);
            chk("tr_stall_mtgt", 32'(MemoryTarget), 'h10);
            tick();
        end
        apply('h010, 1, 0, 1, 0, "tr_go"); chk("tr_go_accld", 32'(AccLoadEn), 1); tick();
        chk("tr_state", 32'(State), 0);

        apply('h00C, 1, 0, 0, 0, "strc_op"); tick();
        apply('h042, 1, 0, 0, 0, "strc_tgt");
        chk("strc_wr", 32'({MemWrEn, MemAddrCtrl, MemValueCtrl}), 3'b111);
        tick();

        apply('h014, 1, 0, 0, 0, "abort_op"); tick();
        apply('h010, 1, 0, 1, 1, "abort_rst");
        chk("abort_no_load", 32'({AccLoadEn, MemRdEn}), 0);
        tick(); chk("abort_state", 32'(State), 0);

        apply('h00F, 1, 0, 0, 0, "done"); chk("done_ack", 32'(Ack), 1); tick();
        chk("halt_state", 32'(State), 3);
        for (int k = 0; k < 4; k++) begin
            apply('h00E + k, 1, 3'(k), 1, 0, "halted");
            chk("halt_ack", 32'(Ack), 1);
            chk("halt_nowr", 32'(MemWrEn), 0);
            tick();
        end
        apply(0, 1, 0, 0, 1, "halt_rst"); tick();
        chk("halt_rst_state", 32'(State), 0);

        apply('h00F, 1, 0, 0, 1, "done_rst"); chk("done_rst_ack", 32'(Ack), 0); tick();
        chk("done_rst_state", 32'(State), 0);

        apply('h007, 1, 0, 0, 0, "undef"); tick();
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        chk("undef_ill", 32'(Illegal), 1);
        chk("undef_state", 32'(State), 3);
        chk("undef_ack", 32'(Ack), 0);
`else
        chk("undef_ill", 32'(Illegal), 0);
        chk("undef_state", 32'(State), 0);
`endif
        apply(0, 1, 0, 0, 1, "undef_rst"); tick();

        for (int i = 0; i < 1500; i++) begin
            ins = int'($urandom_range(0, 511));
            r   = int'($urandom_range(0, 9));
            v   = (r != 0);
            c   = 3'($urandom_range(0, 7));
            mr  = ($urandom_range(0, 2) != 0);
            rs  = ($urandom_range(0, 39) == 0);
            apply(ins, v, c, mr, rs, "rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
